// File: rtl/accel_pkg.sv
// Shared types for the accelerometer signal path: axis sample width and the x/y/z triple.
package accel_pkg;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] z;
    } accel_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO of accel_sample_t triples. dout is a registered copy of the
// entry at the next read pointer, so the whole triple always changes on one edge.
module sample_fifo
    import accel_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  accel_sample_t din,
    output accel_sample_t dout,
    output logic [CW-1:0] count
);

    accel_sample_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0] count_next;
    logic          rd_en, wr_en, bypass;

    assign rd_en      = pop && (count != '0);
    assign wr_en      = push && ((count != CW'(DEPTH)) || rd_en);
    assign rd_next    = rd_ptr + AW'(rd_en);
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    // The incoming triple becomes the head when nothing older survives this edge.
    assign bypass     = wr_en && (count == CW'(rd_en));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            count <= count_next;
            // On the transition to empty the last popped triple stays visible.
            if (count_next != '0)
                dout <= bypass ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/accel_sample_mailbox.sv
// Mailbox between the filtered accelerometer stream and the Nios PIOs: buffers triples,
// pops one per cpu_ack level change, and counts triples dropped while full.
module accel_sample_mailbox #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int OVF_W  = 8
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_x,
    input  logic [DATA_W-1:0]          in_y,
    input  logic [DATA_W-1:0]          in_z,
    input  logic                       cpu_ack,
    output logic [DATA_W-1:0]          out_x,
    output logic [DATA_W-1:0]          out_y,
    output logic [DATA_W-1:0]          out_z,
    output logic                       data_interrupt,
    output logic                       available,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [OVF_W-1:0]           overflow_count
);
    import accel_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    accel_sample_t din, dout;
    logic [CW-1:0] count, level_next;
    logic          ack_prev, pop_req, pop, push, drop;

    assign din = '{x: in_x, y: in_y, z: in_z};

    assign pop_req    = (cpu_ack != ack_prev);
    assign pop        = pop_req && (count != '0);
    assign push       = in_valid && ((count != CW'(DEPTH)) || pop);
    assign drop       = in_valid && !push;
    assign level_next = count + CW'(push) - CW'(pop);

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    always_ff @(posedge sys_clk) begin
        // ack_prev tracks the PIO level even in reset so a stale level never pops.
        ack_prev <= cpu_ack;
        if (reset) begin
            data_interrupt <= 1'b0;
            available      <= 1'b1;
            overflow_count <= '0;
        end else begin
            data_interrupt <= (level_next != '0);
            available      <= (level_next != CW'(DEPTH));
            if (drop && (overflow_count != '1))
                overflow_count <= overflow_count + OVF_W'(1);
        end
    end

    assign fill_level = count;
    assign out_x      = dout.x;
    assign out_y      = dout.y;
    assign out_z      = dout.z;

endmodule

// File: tb/tb_accel_sample_mailbox.sv
// Bench for accel_sample_mailbox: directed vector table, hand sequences for reset/saturation,
// then randomized traffic against a queue-based reference model.
module tb_accel_sample_mailbox;
    import accel_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset, in_valid, cpu_ack;
    logic [15:0] in_x, in_y, in_z, out_x, out_y, out_z;
    logic        data_interrupt, available;
    logic [2:0]  fill_level;
    logic [7:0]  overflow_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    accel_sample_mailbox #(.DATA_W(16), .DEPTH(4), .OVF_W(8)) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_z           (in_z),
        .cpu_ack        (cpu_ack),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_z          (out_z),
        .data_interrupt (data_interrupt),
        .available      (available),
        .fill_level     (fill_level),
        .overflow_count (overflow_count)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        accel_sample_t s;
        logic          ack;
        accel_sample_t es;
        logic          eint;
        logic          eav;
        int            elvl;
        int            eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic accel_sample_t mk(int n);
        accel_sample_t r;
        r.x = 16'h1000 + 16'(n);
        r.y = 16'h2000 + 16'(n);
        r.z = 16'hF000 + 16'(n);
        return r;
    endfunction

    function automatic vec_t v(logic rst, logic iv, accel_sample_t s, logic ack,
                               accel_sample_t es, logic eint, logic eav, int elvl, int eovf);
        vec_t r;
        r.rst = rst; r.iv = iv; r.s = s; r.ack = ack;
        r.es = es; r.eint = eint; r.eav = eav; r.elvl = elvl; r.eovf = eovf;
        return r;
    endfunction

    task automatic apply(input logic rst, input logic iv, input accel_sample_t s, input logic ack);
        reset    = rst;
        in_valid = iv;
        in_x     = s.x;
        in_y     = s.y;
        in_z     = s.z;
        cpu_ack  = ack;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input accel_sample_t es, input logic eint,
                         input logic eav, input int elvl, input int eovf);
        n_vec++;
        if (out_x !== es.x || out_y !== es.y || out_z !== es.z || data_interrupt !== eint ||
            available !== eav || fill_level !== 3'(elvl) || overflow_count !== 8'(eovf)) begin
            n_fail++;
            $display("FAIL %s: got xyz=%h/%h/%h int=%b av=%b lvl=%0d ovf=%0d, want xyz=%h/%h/%h int=%b av=%b lvl=%0d ovf=%0d",
                     name, out_x, out_y, out_z, data_interrupt, available, fill_level, overflow_count,
                     es.x, es.y, es.z, eint, eav, elvl, eovf);
        end
    endtask

    accel_sample_t z0, s0;
    accel_sample_t q[$];
    accel_sample_t m_head;
    int            m_ovf;
    logic          m_ack_prev;

    initial begin
        z0 = '0;
        s0 = '{x: 16'h0123, y: 16'hFF00, z: 16'h7FFF};

        // Reset, single push, pop to empty
        tbl.push_back(v(1, 0, z0,     0, z0,     0, 1, 0, 0));
        tbl.push_back(v(0, 1, s0,     0, s0,     1, 1, 1, 0));
        tbl.push_back(v(0, 0, z0,     1, s0,     0, 1, 0, 0));
        // Five pushes into depth 4: one drop
        tbl.push_back(v(0, 1, mk(1),  1, mk(1),  1, 1, 1, 0));
        tbl.push_back(v(0, 1, mk(2),  1, mk(1),  1, 1, 2, 0));
        tbl.push_back(v(0, 1, mk(3),  1, mk(1),  1, 1, 3, 0));
        tbl.push_back(v(0, 1, mk(4),  1, mk(1),  1, 0, 4, 0));
        tbl.push_back(v(0, 1, mk(5),  1, mk(1),  1, 0, 4, 1));
        // Four toggles drain in order
        tbl.push_back(v(0, 0, z0,     0, mk(2),  1, 1, 3, 1));
        tbl.push_back(v(0, 0, z0,     1, mk(3),  1, 1, 2, 1));
        tbl.push_back(v(0, 0, z0,     0, mk(4),  1, 1, 1, 1));
        tbl.push_back(v(0, 0, z0,     1, mk(4),  0, 1, 0, 1));
        // Refill, then push + pop while full
        tbl.push_back(v(0, 1, mk(1),  1, mk(1),  1, 1, 1, 1));
        tbl.push_back(v(0, 1, mk(2),  1, mk(1),  1, 1, 2, 1));
        tbl.push_back(v(0, 1, mk(3),  1, mk(1),  1, 1, 3, 1));
        tbl.push_back(v(0, 1, mk(4),  1, mk(1),  1, 0, 4, 1));
        tbl.push_back(v(0, 1, mk(5),  0, mk(2),  1, 0, 4, 1));
        tbl.push_back(v(0, 0, z0,     1, mk(3),  1, 1, 3, 1));
        tbl.push_back(v(0, 0, z0,     0, mk(4),  1, 1, 2, 1));
        tbl.push_back(v(0, 0, z0,     1, mk(5),  1, 1, 1, 1));
        tbl.push_back(v(0, 0, z0,     0, mk(5),  0, 1, 0, 1));
        // Toggles while empty are forgotten
        tbl.push_back(v(0, 0, z0,     1, mk(5),  0, 1, 0, 1));
        tbl.push_back(v(0, 0, z0,     0, mk(5),  0, 1, 0, 1));
        tbl.push_back(v(0, 1, mk(6),  0, mk(6),  1, 1, 1, 1));
        // Build fill_level=3 with cpu_ack left high
        tbl.push_back(v(0, 1, mk(7),  0, mk(6),  1, 1, 2, 1));
        tbl.push_back(v(0, 0, z0,     1, mk(7),  1, 1, 1, 1));
        tbl.push_back(v(0, 1, mk(8),  1, mk(7),  1, 1, 2, 1));
        tbl.push_back(v(0, 1, mk(9),  1, mk(7),  1, 1, 3, 1));

        reset = 1'b1; in_valid = 1'b0; cpu_ack = 1'b0;
        in_x = '0; in_y = '0; in_z = '0;
        repeat (2) @(posedge sys_clk);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].iv, tbl[i].s, tbl[i].ack);
            check($sformatf("tbl[%0d]", i), tbl[i].es, tbl[i].eint, tbl[i].eav, tbl[i].elvl, tbl[i].eovf);
        end

        // Reset mid-operation with ack held high; the push in the reset cycle is ignored
        apply(1, 1, mk(10), 1);
        check("rst_mid", z0, 0, 1, 0, 0);
        apply(0, 0, z0, 1);
        check("rst_no_pop", z0, 0, 1, 0, 0);
        apply(0, 1, s0, 1);
        check("rst_next_push", s0, 1, 1, 1, 0);

        // Fill, then saturate the overflow counter without disturbing contents
        for (int i = 1; i <= 3; i++) begin
            apply(0, 1, mk(30 + i), 1);
            check($sformatf("fill%0d", i), s0, 1, (i != 3), 1 + i, 0);
        end
        for (int i = 1; i <= 300; i++) begin
            apply(0, 1, mk(99), 1);
            if (i == 1 || i == 254 || i == 255 || i == 300)
                check($sformatf("drop%0d", i), s0, 1, 0, 4, (i > 255) ? 255 : i);
        end
        apply(0, 0, z0, 0);
        check("sat_pop1", mk(31), 1, 1, 3, 255);
        apply(0, 0, z0, 1);
        check("sat_pop2", mk(32), 1, 1, 2, 255);
        apply(0, 0, z0, 0);
        check("sat_pop3", mk(33), 1, 1, 1, 255);
        apply(0, 0, z0, 1);
        check("sat_pop4", mk(33), 0, 1, 0, 255);

        // Randomized traffic against the reference model
        q.delete();
        m_head = '0; m_ovf = 0; m_ack_prev = 1'b1;
        begin
            logic          ack, rst, iv, do_pop;
            accel_sample_t s;
            ack = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                rst = (c == 0) || ($urandom_range(0, 199) == 0);
                iv  = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 9) < 3) ack = ~ack;
                s.x = 16'($urandom); s.y = 16'($urandom); s.z = 16'($urandom);
                if (rst) begin
                    q.delete();
                    m_head = '0;
                    m_ovf  = 0;
                end else begin
                    do_pop = (ack != m_ack_prev) && (q.size() > 0);
                    if (do_pop) void'(q.pop_front());
                    if (iv) begin
                        if (q.size() < 4) q.push_back(s);
                        else if (m_ovf < 255) m_ovf++;
                    end
                    if (q.size() > 0) m_head = q[0];
                end
                m_ack_prev = ack;
                apply(rst, iv, s, ack);
                check($sformatf("rand%0d", c), m_head, q.size() != 0, q.size() != 4, q.size(), m_ovf);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
